// File: rtl/gf_mul_acc.sv
// ---------------------------------------------------------------------------
// gf_mul_acc -- GF(2^M) multiply-accumulate unit
//
// Purpose:
//   Polynomial-basis multiply of in_a * in_b modulo POLY, computed bit-serially
//   (MSB of the multiplier first), one multiplier bit per clock, M clocks per
//   term. Each product is XOR-accumulated; when a term marked in_last finishes,
//   the accumulated sum is presented on out_sum with out_valid and held until
//   out_ready, and the accumulator restarts from zero.
//
// Parameters:
//   M     field width in bits (2..16)
//   POLY  irreducible polynomial, M+1 bits wide with bit M set
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input term valid
//   in_ready   unit can accept a term (depends on state only)
//   in_a       multiplicand (M bits)
//   in_b       multiplier (M bits)
//   in_last    term closes the current accumulation
//   out_valid  out_sum valid
//   out_ready  consumer accepts out_sum
//   out_sum    XOR of all products since the last emitted result (M bits)
// ---------------------------------------------------------------------------
module gf_mul_acc #(
    parameter int         M    = 4,
    parameter logic [M:0] POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_sum
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Low while in reset and for the first edge after release, so in_ready
    // stays low until the unit is actually running.
    logic            r_live;

    logic [M-1:0]    r_a;
    logic [M-1:0]    r_b;        // shifted left each MUL cycle; MSB is the active bit
    logic            r_last;
    logic [M-1:0]    r_p;        // partial product
    logic [M-1:0]    r_acc;
    logic [M-1:0]    r_sum;
    logic [CW-1:0]   r_cnt;

    logic [M-1:0]    w_xt;       // r_p * x mod POLY
    logic [M-1:0]    w_p_next;
    logic            w_accept;
    logic            w_mul_done;

    // Multiply-by-x: shift left and fold the bit that falls off the top back
    // in through the low M bits of the polynomial.
    assign w_xt[0] = r_p[M-1] & POLY[0];
    generate
        for (genvar gi = 1; gi < M; gi++) begin : g_xt
            assign w_xt[gi] = r_p[gi-1] ^ (r_p[M-1] & POLY[gi]);
        end
    endgenerate

    assign w_p_next   = w_xt ^ (r_b[M-1] ? r_a : '0);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_done = (r_cnt == '0);

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_live;
                if (in_valid && r_live) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = r_last ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign out_sum = r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_last  <= 1'b0;
            r_p     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_last <= in_last;
                        r_p    <= '0;
                        r_cnt  <= CW'(M - 1);
                    end
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_b   <= r_b << 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_mul_done) begin
                        if (r_last) begin
                            r_sum <= r_acc ^ w_p_next;
                            r_acc <= '0;
                        end else begin
                            r_acc <= r_acc ^ w_p_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mul_acc.sv
// ---------------------------------------------------------------------------
// tb_gf_mul_acc -- self-checking bench for gf_mul_acc
//
// Two instances: M=4 (POLY x^4+x+1) and M=8 (POLY 0x11D). Directed single-term
// vectors come from a table; bursts, back-pressure and reset corner cases are
// hand-written sequences; a final pass runs random bursts against an
// LSB-first shift-and-add reference multiplier.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf_mul_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v4 = 1'b0, last4 = 1'b0, or4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       rdy4, ov4;
    logic [3:0] sum4;

    logic       v8 = 1'b0, last8 = 1'b0, or8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       rdy8, ov8;
    logic [7:0] sum8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf_mul_acc #(.M(4), .POLY(5'b10011)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4), .in_last(last4),
        .out_valid(ov4), .out_ready(or4), .out_sum(sum4)
    );

    gf_mul_acc #(.M(8), .POLY(9'h11D)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8), .in_last(last8),
        .out_valid(ov8), .out_ready(or8), .out_sum(sum8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(int w);
        return (w == 4) ? rdy4 : rdy8;
    endfunction

    function automatic logic ov(int w);
        return (w == 4) ? ov4 : ov8;
    endfunction

    function automatic logic [15:0] sum(int w);
        return (w == 4) ? {12'h0, sum4} : {8'h0, sum8};
    endfunction

    // LSB-first reference: r ^= a for each set bit of b, a = a*x mod poly.
    function automatic logic [15:0] gfmul(int w, logic [15:0] a, logic [15:0] b);
        logic [16:0] aa;
        logic [16:0] poly;
        logic [15:0] r;
        aa   = {1'b0, a};
        poly = (w == 4) ? 17'h13 : 17'h11D;
        r    = '0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) r = r ^ aa[15:0];
            aa = aa << 1;
            if (aa[w]) aa = aa ^ poly;
        end
        return r;
    endfunction

    task automatic drive_in(int w, logic v, logic [15:0] a, logic [15:0] b, logic last);
        if (w == 4) begin
            v4 = v; a4 = a[3:0]; b4 = b[3:0]; last4 = last;
        end else begin
            v8 = v; a8 = a[7:0]; b8 = b[7:0]; last8 = last;
        end
    endtask

    task automatic set_ordy(int w, logic r);
        if (w == 4) or4 = r; else or8 = r;
    endtask

    // Offer one term, wait for acceptance, then check the M-cycle busy window
    // and what the unit does at its end (out_valid for last, in_ready otherwise).
    task automatic send(int w, logic [15:0] a, logic [15:0] b, logic last, int gap, string name);
        int n = 0;
        for (int g = 0; g < gap; g++) tick();
        drive_in(w, 1'b1, a, b, last);
        while (!rdy(w) && n < 60) begin
            tick();
            n++;
        end
        if (!rdy(w)) begin
            chk({name, "_ready_timeout"}, 32'd0, 32'd1);
            drive_in(w, 1'b0, '0, '0, 1'b0);
            return;
        end
        tick();
        // Scramble operands after acceptance; the unit must not resample them.
        drive_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 1; i <= w; i++) begin
            tick();
            if (i < w)
                chk({name, "_busy"}, {30'd0, rdy(w), ov(w)}, 32'd0);
            else if (last)
                chk({name, "_latency"}, {31'd0, ov(w)}, 32'd1);
            else
                chk({name, "_ready_back"}, {30'd0, rdy(w), ov(w)}, 32'd2);
        end
    endtask

    // Wait for a result, hold it under back-pressure for `stall` cycles, accept.
    task automatic get(int w, logic [15:0] exp, int stall, string name);
        int n = 0;
        while (!ov(w) && n < 60) begin
            tick();
            n++;
        end
        if (!ov(w)) begin
            chk({name, "_valid_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, "_sum"}, {16'd0, sum(w)}, {16'd0, exp});
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({name, "_hold"}, {14'd0, ov(w), rdy(w), sum(w)}, {14'd0, 1'b1, 1'b0, exp});
        end
        set_ordy(w, 1'b1);
        tick();
        set_ordy(w, 1'b0);
        chk({name, "_drop"}, {30'd0, ov(w), rdy(w)}, 32'd1);
    endtask

    task automatic do_reset(string name);
        rst_n = 1'b0;
        #1;
        chk({name, "_in_reset"}, {28'd0, ov4, rdy4, ov8, rdy8}, 32'd0);
        chk({name, "_sum_zero"}, {20'd0, sum4, sum8}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk({name, "_ready_after"}, {28'd0, ov4, rdy4, ov8, rdy8}, 32'h5);
    endtask

    initial begin
        logic [15:0] acc;
        int          len;
        logic [15:0] ra, rb;

        vt[0] = '{a: 4'h2, b: 4'h8, exp: 4'h3};
        vt[1] = '{a: 4'hF, b: 4'hF, exp: 4'hA};
        vt[2] = '{a: 4'h5, b: 4'h1, exp: 4'h5};
        vt[3] = '{a: 4'h0, b: 4'h9, exp: 4'h0};
        vt[4] = '{a: 4'h9, b: 4'h0, exp: 4'h0};
        vt[5] = '{a: 4'h3, b: 4'h7, exp: 4'h9};
        vt[6] = '{a: 4'h8, b: 4'h8, exp: 4'hC};
        vt[7] = '{a: 4'h1, b: 4'h1, exp: 4'h1};

        // Reset state
        #1;
        chk("por_outputs", {28'd0, ov4, rdy4, ov8, rdy8}, 32'd0);
        chk("por_sum", {20'd0, sum4, sum8}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("release_no_ready_yet", {31'd0, rdy4}, 32'd0);
        tick();
        chk("release_ready", {30'd0, rdy4, rdy8}, 32'd3);

        // Single-term table
        for (int i = 0; i < 8; i++) begin
            send(4, {12'd0, vt[i].a}, {12'd0, vt[i].b}, 1'b1, 0, $sformatf("vec%0d", i));
            get(4, {12'd0, vt[i].exp}, 0, $sformatf("vec%0d", i));
        end

        // Two-term burst, then a single term to show the accumulator was cleared
        send(4, 16'h2, 16'h8, 1'b0, 0, "burst_t0");
        chk("burst_no_early_out", {31'd0, ov4}, 32'd0);
        send(4, 16'h3, 16'h7, 1'b1, 0, "burst_t1");
        get(4, 16'hA, 0, "burst");
        send(4, 16'h1, 16'h1, 1'b1, 0, "after_burst");
        get(4, 16'h1, 0, "after_burst");

        // out_ready while idle is ignored; then 5 cycles of back-pressure
        or4 = 1'b1;
        tick();
        tick();
        chk("idle_ordy_ignored", {30'd0, ov4, rdy4}, 32'd1);
        or4 = 1'b0;
        send(4, 16'h5, 16'h1, 1'b1, 0, "bp");
        get(4, 16'h5, 5, "bp");

        // Reset two cycles into MUL with a non-zero accumulator pending
        send(4, 16'h2, 16'h8, 1'b0, 0, "rmul_pre");
        v4 = 1'b1; a4 = 4'h5; b4 = 4'h5; last4 = 1'b1;
        tick();
        v4 = 1'b0;
        tick();
        tick();
        do_reset("rst_mul");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_mul_no_out", {31'd0, ov4}, 32'd0);
        end
        send(4, 16'h3, 16'h7, 1'b1, 0, "rst_mul_next");
        get(4, 16'h9, 0, "rst_mul_next");

        // Reset while holding a result
        send(4, 16'hF, 16'hF, 1'b1, 0, "rout");
        tick();
        chk("rout_valid", {31'd0, ov4}, 32'd1);
        do_reset("rst_out");
        tick();
        chk("rst_out_no_out", {31'd0, ov4}, 32'd0);
        send(4, 16'h2, 16'h8, 1'b1, 0, "rst_out_next");
        get(4, 16'h3, 0, "rst_out_next");

        // M=8 directed: x^7 * x = x^8 = 0x1D; b=1 passes a through
        send(8, 16'h80, 16'h02, 1'b1, 0, "m8_wrap");
        get(8, 16'h1D, 0, "m8_wrap");
        send(8, 16'hA7, 16'h01, 1'b1, 0, "m8_one");
        get(8, 16'hA7, 2, "m8_one");

        // Random bursts against the reference multiplier
        for (int w = 4; w <= 8; w += 4) begin
            for (int k = 0; k < 30; k++) begin
                len = $urandom_range(1, 4);
                acc = '0;
                for (int t = 0; t < len; t++) begin
                    ra  = 16'($urandom) & ((w == 4) ? 16'h000F : 16'h00FF);
                    rb  = 16'($urandom) & ((w == 4) ? 16'h000F : 16'h00FF);
                    acc = acc ^ gfmul(w, ra, rb);
                    send(w, ra, rb, (t == len - 1), $urandom_range(0, 2), $sformatf("rnd%0d_%0d", w, k));
                end
                get(w, acc, $urandom_range(0, 3), $sformatf("rnd%0d_%0d", w, k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
